if_stage: RTL and testbench

//  Instruction-fetch stage ahead of the decode stage. Keeps the fetch PC, issues
//  8-byte-aligned requests to the i-cache and applies the branch predictor's guess.

---
 rtl/if_stage.sv | 152 +++++++++++++++
 tb/tb_if_stage.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues aligned i-cache requests and
// turns each live cache response into one fetch packet for the decoder.
`ifndef EXP_ADEF
`define EXP_ADEF 7'h08
`endif
`ifndef INST_NOP
`define INST_NOP 32'h03400000
`endif

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        set_pc,
    input  logic [31:0] set_pc_target,
    input  logic        id_full,
    input  logic [31:0] bp_pc_next,
    input  logic        bp_first_jmp,
    input  logic [1:0]  bp_unknown,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [63:0] resp_data,
    output logic        out_valid,
    output logic [31:0] out_inst0,
    output logic [31:0] out_inst1,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_next,
    output logic        out_first_jmp,
    output logic [1:0]  out_unknown,
    output logic [6:0]  out_exception
);

    localparam logic [1:0] S_REQ     = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    // discard marks a request still in flight whose response belongs to a stale path
    logic        discard;

    logic [31:0] pkt_pc;
    logic [31:0] pkt_pc_next;
    logic        pkt_first_jmp;
    logic [1:0]  pkt_unknown;
    logic [6:0]  pkt_exception;
    logic [31:0] inst0_q;
    logic [31:0] inst1_q;

    logic        aligned;
    logic        accept;
    logic        resp_live;
    logic        have_pkt;
    logic        present;
    logic [31:0] consume_pc;

    always_comb begin
        aligned    = (pc[1:0] == 2'b00);
        req_valid  = ~rst & (state == S_REQ) & ~discard & aligned;
        accept     = req_valid & req_ready;
        resp_live  = (state == S_WAIT) & resp_valid & ~discard;
        have_pkt   = resp_live | (state == S_PRESENT);
        present    = ~rst & ~flush & ~id_full & have_pkt;
        consume_pc = set_pc ? set_pc_target : pkt_pc_next;
    end

    assign req_addr      = {pc[31:3], 3'b000};
    assign out_valid     = present;
    assign out_inst0     = (state == S_WAIT) ? resp_data[31:0]  : inst0_q;
    assign out_inst1     = (state == S_WAIT) ? resp_data[63:32] : inst1_q;
    assign out_pc        = pkt_pc;
    assign out_pc_next   = pkt_pc_next;
    assign out_first_jmp = pkt_first_jmp;
    assign out_unknown   = pkt_unknown;
    assign out_exception = pkt_exception;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            state         <= S_REQ;
            discard       <= (discard | (state == S_WAIT)) & ~resp_valid;
            pkt_pc        <= '0;
            pkt_pc_next   <= '0;
            pkt_first_jmp <= 1'b0;
            pkt_unknown   <= '0;
            pkt_exception <= '0;
            inst0_q       <= '0;
            inst1_q       <= '0;
        end else begin
            if (discard & resp_valid)
                discard <= 1'b0;

            if (flush) begin
                pc    <= flush_pc;
                state <= S_REQ;
                // any request still owed a response after this edge becomes stale
                discard <= ((discard | (state == S_WAIT)) & ~resp_valid) | accept;
            end else begin
                case (state)
                    S_REQ: begin
                        if (!discard) begin
                            if (!aligned) begin
                                pkt_pc        <= pc;
                                pkt_pc_next   <= pc;
                                pkt_first_jmp <= 1'b0;
                                pkt_unknown   <= '0;
                                pkt_exception <= `EXP_ADEF;
                                inst0_q       <= `INST_NOP;
                                inst1_q       <= `INST_NOP;
                                state         <= S_PRESENT;
                            end else if (accept) begin
                                pkt_pc        <= pc;
                                pkt_pc_next   <= bp_pc_next;
                                pkt_first_jmp <= bp_first_jmp;
                                pkt_unknown   <= bp_unknown;
                                pkt_exception <= '0;
                                state         <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (resp_valid) begin
                            if (discard) begin
                                state <= S_REQ;
                            end else if (present) begin
                                pc    <= consume_pc;
                                state <= S_REQ;
                            end else begin
                                inst0_q <= resp_data[31:0];
                                inst1_q <= resp_data[63:32];
                                state   <= S_PRESENT;
                            end
                        end
                    end
                    S_PRESENT: begin
                        if (present) begin
                            pc    <= consume_pc;
                            state <= S_REQ;
                        end
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: the bench acts as i-cache and predictor, keeps a transaction
// model (in-flight request, held packet) and compares every cycle.
`ifndef EXP_ADEF
`define EXP_ADEF 7'h08
`endif
`ifndef INST_NOP
`define INST_NOP 32'h03400000
`endif

module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        rst, flush, set_pc, id_full, req_ready, resp_valid;
    logic [31:0] flush_pc, set_pc_target;
    logic [31:0] bp_pc_next;
    logic        bp_first_jmp;
    logic [1:0]  bp_unknown;
    logic [63:0] resp_data;
    logic        req_valid, out_valid, out_first_jmp;
    logic [31:0] req_addr, out_inst0, out_inst1, out_pc, out_pc_next;
    logic [1:0]  out_unknown;
    logic [6:0]  out_exception;

    logic        bp_force = 1'b0;
    logic [31:0] bp_force_val = '0;

    int total = 0;
    int bad = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    // predictor stand-in: sequential fallback unless a jump is forced
    assign bp_pc_next = bp_force ? bp_force_val : req_addr + 32'd8;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
        .set_pc(set_pc), .set_pc_target(set_pc_target), .id_full(id_full),
        .bp_pc_next(bp_pc_next), .bp_first_jmp(bp_first_jmp), .bp_unknown(bp_unknown),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .out_valid(out_valid), .out_inst0(out_inst0), .out_inst1(out_inst1),
        .out_pc(out_pc), .out_pc_next(out_pc_next), .out_first_jmp(out_first_jmp),
        .out_unknown(out_unknown), .out_exception(out_exception)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcn;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        fj;
        logic [1:0]  unk;
        logic [6:0]  exc;
    } pkt_t;

    logic [31:0] m_pc = RST_PC;
    logic        pend = 1'b0;
    logic        pend_live = 1'b0;
    logic        held = 1'b0;
    pkt_t        pend_pkt;
    pkt_t        held_pkt;

    always @(negedge clk) begin : model_check
        pkt_t        cand;
        logic        e_req, have, e_ov, acc, pend_o, held_o;
        logic [31:0] pc_o;
        if (chk_on) begin
            e_req = !rst && !pend && !held && (m_pc[1:0] == 2'b00);
            have  = 1'b0;
            cand  = held_pkt;
            if (held) begin
                have = 1'b1;
            end else if (pend && pend_live && resp_valid) begin
                have    = 1'b1;
                cand    = pend_pkt;
                cand.i0 = resp_data[31:0];
                cand.i1 = resp_data[63:32];
            end
            e_ov = have && !id_full && !flush && !rst;

            chk("req_valid", req_valid, e_req);
            chk("req_addr", req_addr, m_pc & 32'hffff_fff8);
            chk("out_valid", out_valid, e_ov);
            if (e_ov) begin
                chk("pkt_pc", out_pc, cand.pc);
                chk("pkt_pc_next", out_pc_next, cand.pcn);
                chk("pkt_inst0", out_inst0, cand.i0);
                chk("pkt_inst1", out_inst1, cand.i1);
                chk("pkt_first_jmp", out_first_jmp, cand.fj);
                chk("pkt_unknown", out_unknown, cand.unk);
                chk("pkt_exception", out_exception, cand.exc);
            end

            pc_o = m_pc; pend_o = pend; held_o = held;
            if (rst) begin
                m_pc = RST_PC;
                held = 1'b0;
                if (pend && !resp_valid) pend_live = 1'b0;
                else pend = 1'b0;
            end else begin
                acc = e_req && req_ready;
                if (pend && resp_valid) pend = 1'b0;
                if (e_ov) begin
                    held = 1'b0;
                    m_pc = set_pc ? set_pc_target : cand.pcn;
                end else if (have && !flush) begin
                    held     = 1'b1;
                    held_pkt = cand;
                end
                if (!flush && !pend_o && !held_o && pc_o[1:0] != 2'b00) begin
                    held     = 1'b1;
                    held_pkt = '{pc: pc_o, pcn: pc_o, i0: `INST_NOP, i1: `INST_NOP,
                                 fj: 1'b0, unk: 2'b00, exc: `EXP_ADEF};
                end
                if (acc) begin
                    pend      = 1'b1;
                    pend_live = 1'b1;
                    pend_pkt  = '{pc: pc_o, pcn: bp_pc_next, i0: '0, i1: '0,
                                  fj: bp_first_jmp, unk: bp_unknown, exc: 7'd0};
                end
                if (flush) begin
                    m_pc = flush_pc;
                    held = 1'b0;
                    if (pend) pend_live = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 0; flush_pc = '0; set_pc = 0; set_pc_target = '0;
        id_full = 0; req_ready = 0; resp_valid = 0; resp_data = '0;
    endtask

    task automatic finish_cycle();
        step();
        idle();
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        step();
        chk_on = 1'b1;
        step();
        smp();
        chk("rst_req_valid", req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_pc_next", out_pc_next, 0);
        chk("rst_out_exception", out_exception, 0);
        chk("rst_req_addr", req_addr, RST_PC);
        step();
        rst = 0;
    endtask

    // issue one request from REQ, respond next cycle; ends at the packet cycle's negedge
    task automatic fetch(input logic [31:0] exp_addr, input logic [63:0] data, input int full_cyc);
        req_ready = 1;
        smp();
        chk("fetch_req_valid", req_valid, 1);
        chk("fetch_req_addr", req_addr, exp_addr);
        step();
        req_ready = 0;
        resp_valid = 1;
        resp_data = data;
        id_full = (full_cyc > 0);
        for (int k = 0; k < full_cyc; k++) begin
            smp();
            chk("full_no_valid", out_valid, 0);
            chk("full_no_req", req_valid, 0);
            step();
            resp_valid = 0;
        end
        id_full = 0;
        smp();
        chk("fetch_pkt_valid", out_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bp_first_jmp = 0;
        bp_unknown = 2'b00;

        // basic fetch after reset
        do_reset();
        fetch(32'h1c000000, 64'h00000002_02800000, 0);
        chk("t1_pc", out_pc, 32'h1c000000);
        chk("t1_pc_next", out_pc_next, 32'h1c000008);
        chk("t1_inst0", out_inst0, 32'h02800000);
        chk("t1_inst1", out_inst1, 32'h00000002);
        chk("t1_exc", out_exception, 0);
        finish_cycle();
        chk("t1_model_pc", m_pc, 32'h1c000008);
        smp();
        chk("t1_single_pkt", out_valid, 0);
        chk("t1_next_addr", req_addr, 32'h1c000008);
        step();

        // decoder full for 5 cycles
        do_reset();
        fetch(32'h1c000000, 64'h11111111_22222222, 5);
        chk("t2_pc", out_pc, 32'h1c000000);
        chk("t2_inst0", out_inst0, 32'h22222222);
        chk("t2_inst1", out_inst1, 32'h11111111);
        finish_cycle();
        smp();
        chk("t2_next_valid", req_valid, 1);
        chk("t2_next_addr", req_addr, 32'h1c000008);
        step();

        // flush while waiting, late response dropped
        do_reset();
        req_ready = 1;
        smp();
        step();
        req_ready = 0;
        flush = 1; flush_pc = 32'h1c000100;
        smp();
        chk("t3_flush_no_pkt", out_valid, 0);
        finish_cycle();
        resp_valid = 1; resp_data = 64'hdeadbeef_deadbeef;
        smp();
        chk("t3_stale_dropped", out_valid, 0);
        chk("t3_stale_blocks_req", req_valid, 0);
        finish_cycle();
        fetch(32'h1c000100, 64'h33333333_44444444, 0);
        chk("t3_pc", out_pc, 32'h1c000100);
        chk("t3_pc_next", out_pc_next, 32'h1c000108);
        finish_cycle();

        // set_pc ignored outside packet, honoured in packet cycle
        req_ready = 1; set_pc = 1; set_pc_target = 32'h1c000abc;
        smp();
        chk("t4_req_addr", req_addr, 32'h1c000108);
        step();
        req_ready = 0; set_pc = 1; set_pc_target = 32'h1c000040;
        resp_valid = 1; resp_data = 64'h55555555_66666666;
        smp();
        chk("t4_pkt_valid", out_valid, 1);
        chk("t4_pkt_pc_next", out_pc_next, 32'h1c000110);
        finish_cycle();
        smp();
        chk("t4_set_pc_redirect", req_addr, 32'h1c000040);
        step();
        // flush beats set_pc in the same packet cycle
        req_ready = 1;
        smp();
        step();
        req_ready = 0; resp_valid = 1; resp_data = 64'h77777777_88888888;
        flush = 1; flush_pc = 32'h1c000080; set_pc = 1; set_pc_target = 32'h1c000300;
        smp();
        chk("t4_flush_blocks_pkt", out_valid, 0);
        finish_cycle();
        smp();
        chk("t4_flush_wins", req_addr, 32'h1c000080);
        chk("t4_no_stale", req_valid, 1);
        step();

        // misaligned target -> ADEF packet
        flush = 1; flush_pc = 32'h1c000102;
        finish_cycle();
        chk("t5_model_pc", m_pc, 32'h1c000102);
        smp();
        chk("t5_no_req", req_valid, 0);
        step();
        smp();
        chk("t5_valid", out_valid, 1);
        chk("t5_exc", out_exception, `EXP_ADEF);
        chk("t5_inst0", out_inst0, `INST_NOP);
        chk("t5_inst1", out_inst1, `INST_NOP);
        chk("t5_pc", out_pc, 32'h1c000102);
        chk("t5_pc_next", out_pc_next, 32'h1c000102);
        step();
        smp();
        chk("t5_still_no_req", req_valid, 0);
        step();
        // held ADEF packet dropped by flush; set up predicted jump for next fetch
        flush = 1; flush_pc = 32'h1c000004;
        bp_force = 1; bp_force_val = 32'h1c000200; bp_first_jmp = 1; bp_unknown = 2'b10;
        smp();
        chk("t5_flush_drops_held", out_valid, 0);
        finish_cycle();

        // odd-word start with predicted jump
        fetch(32'h1c000000, 64'h99999999_aaaaaaaa, 0);
        chk("t6_pc", out_pc, 32'h1c000004);
        chk("t6_first_jmp", out_first_jmp, 1);
        chk("t6_pc_next", out_pc_next, 32'h1c000200);
        chk("t6_unknown", out_unknown, 2'b10);
        finish_cycle();
        bp_force = 0; bp_first_jmp = 0; bp_unknown = 2'b00;
        smp();
        chk("t6_next_addr", req_addr, 32'h1c000200);
        step();

        // flush in the same cycle the request is accepted
        req_ready = 1; flush = 1; flush_pc = 32'h1c000400;
        smp();
        finish_cycle();
        smp();
        chk("t7_stale_blocks_req", req_valid, 0);
        step();
        smp();
        step();
        resp_valid = 1; resp_data = 64'hbbbbbbbb_cccccccc;
        smp();
        chk("t7_stale_dropped", out_valid, 0);
        finish_cycle();
        fetch(32'h1c000400, 64'hdddddddd_eeeeeeee, 0);
        chk("t7_pc", out_pc, 32'h1c000400);
        finish_cycle();

        // reset while waiting: late response dropped
        req_ready = 1;
        smp();
        step();
        req_ready = 0;
        rst = 1;
        smp();
        step();
        rst = 0;
        resp_valid = 1; resp_data = 64'h12345678_9abcdef0;
        smp();
        chk("t8_rst_stale_dropped", out_valid, 0);
        chk("t8_rst_stale_no_req", req_valid, 0);
        finish_cycle();
        fetch(RST_PC, 64'h0badf00d_cafef00d, 0);
        chk("t8_pc", out_pc, RST_PC);
        chk("t8_inst0", out_inst0, 32'hcafef00d);
        finish_cycle();
        smp();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
